// File: rtl/c499_lock_pkg.sv
// Shared constants and the loader state type for the c499 key-delivery path.
package c499_lock_pkg;

  localparam int         KEY_W_DEF  = 10;
  localparam logic [3:0] HEADER_DEF = 4'b1010;
  localparam int         FRAME_LEN  = 4 + KEY_W_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_KEY,
    ST_PAR,
    ST_ERR
  } key_ld_state_t;

endpackage

// File: rtl/c499_key_loader.sv
// Bit-serial key loader for the locked c499 core: header check, LSB-first key,
// even parity, then atomic commit. Any error zeroes the key (fail-secure).
module c499_key_loader
  import c499_lock_pkg::*;
#(
  parameter int         KEY_W   = KEY_W_DEF,
  parameter logic [3:0] HEADER  = HEADER_DEF,
  parameter int         TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             load_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_KEY_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(3);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT - 1);

  key_ld_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             load_err_q, load_err_d;

  logic       in_frame;
  logic       accept;
  logic       go_err;
  logic [3:0] hdr_sh;

  assign in_frame = (state_q == ST_HDR) || (state_q == ST_KEY) || (state_q == ST_PAR);
  assign accept   = sin_valid && in_frame;
  // Header is checked MSB first: shifting left by the count puts the expected bit at [3].
  assign hdr_sh   = HEADER << cnt_q[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    shadow_d    = shadow_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    load_err_d  = load_err_q;
    go_err      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (load_start) begin
          state_d    = ST_HDR;
          cnt_d      = '0;
          tmo_d      = '0;
          shadow_d   = '0;
          load_err_d = 1'b0;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (sin_data != hdr_sh[3]) begin
            go_err = 1'b1;
          end else if (cnt_q == CNT_HDR_LAST) begin
            state_d = ST_KEY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_KEY: begin
        if (accept) begin
          for (int i = 0; i < KEY_W; i++) begin
            if (cnt_q == CNT_W'(i)) shadow_d[i] = sin_data;
          end
          if (cnt_q == CNT_KEY_LAST) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (accept) begin
          if (sin_data == ^shadow_q) begin
            state_d     = ST_IDLE;
            key_d       = shadow_q;
            key_valid_d = 1'b1;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle-gap watchdog: counts consecutive non-accept cycles inside a frame.
    if (in_frame) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        go_err = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (go_err) begin
      state_d     = ST_ERR;
      key_d       = '0;
      key_valid_d = 1'b0;
      load_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shadow_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
    end
  end

  assign sin_ready = in_frame;
  assign busy      = in_frame;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader: frames are hand-written bit streams in send order.
module tb_c499_key_loader;
  import c499_lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_data = 1'b0;
  logic       sin_ready;
  logic [9:0] key;
  logic       key_valid;
  logic       load_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Send order: header MSB first | key LSB first | parity.
  localparam logic [14:0] FR_2C5     = 15'b1010_1010001101_1;
  localparam logic [14:0] FR_155     = 15'b1010_1010101010_1;
  localparam logic [14:0] FR_2C5_BAD = 15'b1010_1010001101_0;

  c499_key_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .sin_valid  (sin_valid),
    .sin_data   (sin_data),
    .sin_ready  (sin_ready),
    .key        (key),
    .key_valid  (key_valid),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends f[hi] down to f[lo], one accepted bit per cycle.
  task automatic send_range(input logic [14:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sin_valid = 1'b1;
      sin_data  = f[i];
      tick();
    end
    sin_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_key", key, 10'h000);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_sin_ready", sin_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_sin_ready", sin_ready, 1'b0);

    // Good frame: ready one cycle after load_start, key lands after the 15th bit
    start();
    chk("good_ready_c1", sin_ready, 1'b1);
    chk("good_busy_c1", busy, 1'b1);
    send_range(FR_2C5, 14, 1);
    chk("good_key_before_commit", key, 10'h000);
    chk("good_valid_before_commit", key_valid, 1'b0);
    send_range(FR_2C5, 0, 0);
    chk("good_key", key, 10'h2C5);
    chk("good_key_valid", key_valid, 1'b1);
    chk("good_load_err", load_err, 1'b0);
    chk("good_busy_done", busy, 1'b0);

    // Reload: old key held on every cycle until the commit
    start();
    chk("reload_hold_c1", key, 10'h2C5);
    for (int b = 14; b >= 1; b--) begin
      send_range(FR_155, b, b);
      chk($sformatf("reload_hold_bit%0d", b), {key_valid, key}, {1'b1, 10'h2C5});
    end
    send_range(FR_155, 0, 0);
    chk("reload_key", key, 10'h155);
    chk("reload_valid", key_valid, 1'b1);

    // Bad parity zeroes the committed key
    start();
    send_range(FR_2C5_BAD, 14, 0);
    chk("badpar_key", key, 10'h000);
    chk("badpar_valid", key_valid, 1'b0);
    chk("badpar_err", load_err, 1'b1);
    chk("badpar_busy", busy, 1'b0);
    chk("badpar_ready", sin_ready, 1'b0);

    // Restart from ERR clears load_err; 63-cycle gaps mid-KEY still succeed
    start();
    chk("restart_err_clr", load_err, 1'b0);
    chk("restart_busy", busy, 1'b1);
    send_range(FR_2C5, 14, 8);
    idle(63);
    chk("gap63_busy", busy, 1'b1);
    send_range(FR_2C5, 7, 4);
    idle(63);
    send_range(FR_2C5, 3, 0);
    chk("gap63_key", key, 10'h2C5);
    chk("gap63_valid", key_valid, 1'b1);
    chk("gap63_err", load_err, 1'b0);

    // 64-cycle gap times out
    start();
    send_range(FR_155, 14, 8);
    idle(63);
    chk("tmo_63_busy", busy, 1'b1);
    chk("tmo_63_key_held", key, 10'h2C5);
    idle(1);
    chk("tmo_64_busy", busy, 1'b0);
    chk("tmo_64_key", key, 10'h000);
    chk("tmo_64_err", load_err, 1'b1);

    // Bad header: ERR on the 2nd accepted bit, later bits refused
    start();
    sin_valid = 1'b1;
    sin_data  = 1'b1;
    tick();
    chk("badhdr_bit1_ready", sin_ready, 1'b1);
    tick();
    chk("badhdr_bit2_ready", sin_ready, 1'b0);
    chk("badhdr_err", load_err, 1'b1);
    idle(0);
    send_range(FR_2C5, 14, 10);
    chk("badhdr_ignored_ready", sin_ready, 1'b0);
    chk("badhdr_ignored_key", key, 10'h000);

    // Reset mid-KEY clears a previously valid key
    start();
    send_range(FR_2C5, 14, 0);
    chk("pre_rst_key", key, 10'h2C5);
    start();
    send_range(FR_155, 14, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_key", key, 10'h000);
    chk("midrst_valid", key_valid, 1'b0);
    chk("midrst_err", load_err, 1'b0);
    chk("midrst_ready", sin_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);

    // load_start mid-KEY is ignored; the concurrent bit is still accepted
    start();
    send_range(FR_155, 14, 7);
    load_start = 1'b1;
    send_range(FR_155, 6, 6);
    load_start = 1'b0;
    send_range(FR_155, 5, 0);
    chk("ignstart_key", key, 10'h155);
    chk("ignstart_valid", key_valid, 1'b1);
    chk("ignstart_err", load_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
